// File: rtl/axi4lite_pkg.sv
// Shared types and constants for the AXI4-Lite manager and its wait timer.
package axi4lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AW   = 3'd1,
    W    = 3'd2,
    B    = 3'd3,
    AR   = 3'd4,
    R    = 3'd5,
    RSP  = 3'd6
  } state_e;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

  // States in which the manager is waiting on the subordinate.
  function automatic logic is_wait_state(state_e s);
    return s inside {AW, W, B, AR, R};
  endfunction

endpackage

// File: rtl/axi4lite_wait_timer.sv
// Saturating wait-cycle counter; hit is registered and high while the count equals LIMIT.
module axi4lite_wait_timer
  import axi4lite_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LIMIT);
  localparam logic LIMIT_ON = (LIMIT != 0);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt_c;

  always_comb begin
    cnt_nxt_c = cnt;
    if (clr) begin
      cnt_nxt_c = '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt_nxt_c = cnt + CNT_W'(1);
    end
  end

  // LIMIT of 0 disables the timer: the count never leaves 0 and hit stays low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      hit <= 1'b0;
    end else begin
      cnt <= cnt_nxt_c;
      hit <= LIMIT_ON && (cnt_nxt_c == CNT_MAX);
    end
  end

endmodule

// File: rtl/axi4lite_manager.sv
// AXI4-Lite manager: one command at a time, AW->W->B for writes and AR->R for reads.
// Every output is a register, so no input reaches an output combinationally.
module axi4lite_manager
  import axi4lite_pkg::*;
#(
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  input  logic [2:0]            cmd_prot,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_resp,

  output logic                  err_timeout,
  output logic                  err_resp,

  output logic [ADDR_W-1:0]     M_AXI_AWADDR,
  output logic [2:0]            M_AXI_AWPROT,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,

  output logic [DATA_W-1:0]     M_AXI_WDATA,
  output logic [DATA_W/8-1:0]   M_AXI_WSTRB,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,

  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY,

  output logic [ADDR_W-1:0]     M_AXI_ARADDR,
  output logic [2:0]            M_AXI_ARPROT,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,

  input  logic [DATA_W-1:0]     M_AXI_RDATA,
  input  logic [1:0]            M_AXI_RRESP,
  input  logic                  M_AXI_RVALID,
  output logic                  M_AXI_RREADY
);

  localparam int unsigned STRB_W = DATA_W / 8;

  state_e              state;
  logic                lat_write;
  logic [DATA_W-1:0]   lat_wdata;
  logic [STRB_W-1:0]   lat_wstrb;

  logic cmd_fire_c;
  logic aw_fire_c;
  logic w_fire_c;
  logic ar_fire_c;
  logic tmr_clr_c;
  logic tmr_en_c;
  logic tmr_hit;

  always_comb begin
    cmd_fire_c = (state == IDLE) && cmd_valid && cmd_ready;
    aw_fire_c  = M_AXI_AWVALID && M_AXI_AWREADY;
    w_fire_c   = M_AXI_WVALID && M_AXI_WREADY;
    ar_fire_c  = M_AXI_ARVALID && M_AXI_ARREADY;
    // Every transition into a wait state restarts the wait count.
    tmr_clr_c  = cmd_fire_c || aw_fire_c || w_fire_c || ar_fire_c;
    tmr_en_c   = is_wait_state(state);
  end

  axi4lite_wait_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (S_AXI_ACLK),
    .rst_n (S_AXI_ARESETN),
    .clr   (tmr_clr_c),
    .en    (tmr_en_c),
    .hit   (tmr_hit)
  );

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      lat_write     <= 1'b0;
      lat_wdata     <= '0;
      lat_wstrb     <= '0;
      rsp_valid     <= 1'b0;
      rsp_write     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= 2'b00;
      err_timeout   <= 1'b0;
      err_resp      <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_AWPROT  <= PROT_DEFAULT;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARADDR  <= '0;
      M_AXI_ARPROT  <= PROT_DEFAULT;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
    end else begin
      if (tmr_hit) begin
        err_timeout <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_fire_c) begin
            cmd_ready <= 1'b0;
            lat_write <= cmd_write;
            lat_wdata <= cmd_wdata;
            lat_wstrb <= cmd_wstrb;
            if (cmd_write) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_AWADDR  <= cmd_addr;
              M_AXI_AWPROT  <= cmd_prot;
              state         <= AW;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              M_AXI_ARADDR  <= cmd_addr;
              M_AXI_ARPROT  <= cmd_prot;
              state         <= AR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        AW: begin
          if (aw_fire_c) begin
            M_AXI_AWVALID <= 1'b0;
            M_AXI_AWADDR  <= '0;
            M_AXI_AWPROT  <= PROT_DEFAULT;
            M_AXI_WVALID  <= 1'b1;
            M_AXI_WDATA   <= lat_wdata;
            M_AXI_WSTRB   <= lat_wstrb;
            state         <= W;
          end
        end

        W: begin
          if (w_fire_c) begin
            M_AXI_WVALID <= 1'b0;
            M_AXI_WDATA  <= '0;
            M_AXI_WSTRB  <= '0;
            M_AXI_BREADY <= 1'b1;
            state        <= B;
          end
        end

        B: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= lat_write;
            rsp_rdata    <= '0;
            rsp_resp     <= M_AXI_BRESP;
            if (resp_e'(M_AXI_BRESP) == EXOKAY) begin
              err_resp <= 1'b1;
            end
            state        <= RSP;
          end
        end

        AR: begin
          if (ar_fire_c) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_ARADDR  <= '0;
            M_AXI_ARPROT  <= PROT_DEFAULT;
            M_AXI_RREADY  <= 1'b1;
            state         <= R;
          end
        end

        R: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            rsp_valid    <= 1'b1;
            rsp_write    <= lat_write;
            rsp_rdata    <= M_AXI_RDATA;
            rsp_resp     <= M_AXI_RRESP;
            if (resp_e'(M_AXI_RRESP) == EXOKAY) begin
              err_resp <= 1'b1;
            end
            state        <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/axi4lite_manager.md
# axi4lite_manager

AXI4-Lite manager (initiator) that turns a single-command request/response interface into strictly ordered AXI4-Lite transactions. It is the manager end that drives our AXI4-Lite subordinate register blocks. It runs one transaction at a time: AW→W→B for writes and AR→R for reads. Every bus output honours the subordinate-side protocol rules: reset values, VALID stability, payload stability and strict channel ordering.

## Interface
Parameters:
- ADDR_W, 4: AXI address width.
- DATA_W, 32: AXI data width. Must be 32.
- TIMEOUT_CYCLES, 256: wait-cycle limit per AXI channel. 0 disables the timeout.

Ports:
- S_AXI_ACLK  in  1  clock; single clock domain.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  target address.
- cmd_wdata  in  DATA_W  write data.
- cmd_wstrb  in  DATA_W/8  write strobes.
- cmd_prot  in  3  AxPROT value.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_write  out  1  echoes cmd_write.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP.
- err_timeout  out  1  sticky; cleared only by reset.
- err_resp  out  1  sticky; set when a response of 2'b01 (EXOKAY, illegal in AXI4-Lite) is received.
- M_AXI_AWADDR/AWPROT/AWVALID, AWREADY  out/out/out, in  ADDR_W/3/1, 1.
- M_AXI_WDATA/WSTRB/WVALID, WREADY  out/out/out, in  DATA_W/DATA_W/8/1, 1.
- M_AXI_BRESP, BVALID, BREADY  in, in, out  2, 1, 1.
- M_AXI_ARADDR/ARPROT/ARVALID, ARREADY  out/out/out, in  ADDR_W/3/1, 1.
- M_AXI_RDATA, RRESP, RVALID, RREADY  in, in, in, out  DATA_W, 2, 1, 1.

## Operation
- FSM states: IDLE, AW, W, B, AR, R, RSP.
- IDLE: cmd_ready=1. On cmd handshake, latch all cmd fields, then go to AW (write) or AR (read).
- AW: drive AWVALID=1 with latched AWADDR/AWPROT. On AWVALID&&AWREADY, go to W.
- W: drive WVALID=1 with latched WDATA/WSTRB. On handshake, go to B. WVALID is never asserted before the AW handshake has completed.
- B: drive BREADY=1. On BVALID, capture BRESP into rsp_resp, go to RSP.
- AR: drive ARVALID=1 with latched ARADDR/ARPROT. On handshake, go to R.
- R: drive RREADY=1. On RVALID, capture RDATA/RRESP, go to RSP.
- RSP: drive rsp_valid=1 with stable rsp_* fields. On rsp_ready, go to IDLE.
- Once asserted, a VALID stays high and its payload stays constant until READY is seen. No channel ever withdraws VALID.
- Each AXI payload register returns to 0 in the cycle after its handshake. ADDR, PROT, WDATA and WSTRB are therefore 0 whenever the matching VALID is low.
- Timeout counter:
  - Clears on entry to each of AW, W, B, AR, R.
  - Increments every cycle spent in that state, saturating.
  - When it equals TIMEOUT_CYCLES, err_timeout is set.
  - The FSM keeps waiting; the protocol forbids abandoning the transaction.
- err_resp is set on a captured response of 2'b01. rsp_resp still forwards the raw value.

## Timing
- Reset value of all outputs is 0, except cmd_ready. cmd_ready is 0 while reset is asserted and 1 in the first cycle after release. The FSM resets to IDLE.
- Reset mid-operation: ARESETN sampled low at edge N forces every VALID/READY output and every payload to 0 from edge N onward. An in-flight transaction and any pending response are discarded.
- Write latency, with cmd handshake at edge N:
  - AWVALID high from N+1.
  - If AWREADY is already high, WVALID at N+2 and BREADY at N+3.
  - If BVALID is present, rsp_valid at N+4.
  - Minimum write latency: 4 cycles from command to response.
- Read latency: ARVALID at N+1, RREADY at N+2, rsp_valid at N+3 at minimum.
- Each wait cycle on a READY or VALID adds one cycle to the state it occurs in.
- A new command is accepted only in IDLE, so the earliest next cmd handshake is the edge after rsp handshake.
- Combinational paths: cmd_ready, rsp_valid and all AXI outputs are registered or decoded from state only. No input-to-output combinational path exists.

## Structure
- Package axi4lite_pkg holds:
  - the resp_e enum: OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11;
  - the state_e FSM enum;
  - the PROT_DEFAULT=3'b000 constant.
- One sub-module, axi4lite_wait_timer: a saturating counter with a clear input and a hit output, width $clog2(TIMEOUT_CYCLES+1).

## Test plan
- Write cmd addr=4'h8, data=32'hDEADBEEF, strb=4'hF, with the subordinate always ready → AWVALID N+1, WVALID N+2, BREADY N+3, rsp_valid N+4, rsp_resp=00, rsp_rdata=0.
- Read addr=4'h4 with ARREADY delayed 3 cycles and RDATA=32'h12345678 → ARVALID and ARADDR stable for 4 cycles, rsp_rdata=32'h12345678.
- Write with AWREADY=0 throughout → WVALID never rises. AWVALID stays high; err_timeout rises after 256 cycles and the FSM stays in AW.
- BRESP=2'b01 → rsp_resp=01, err_resp=1 and stays set across later OKAY transactions.
- ARESETN low during state W → next cycle all VALIDs=0, payloads=0 and cmd_ready=0. After release, cmd_ready=1, and a fresh read completes normally.
- rsp_ready held 0 for 5 cycles → rsp_valid and rsp_* fields stable, cmd_ready=0 and no AXI VALID asserted.
